comma_aligner: RTL

Receive-side word aligner directly upstream of the 8b/10b decoder. It takes unaligned 10-bit parallel words from the deserializer and searches every bit offset for the K28.5 comma. It locks symbol alignment with a hysteresis state machine and then presents byte-aligned 10-bit symbols on the bus that feeds the decoder's `datin`. Bit 9 is the first serial bit (`a`), and bit 0 is the last (`j`).

---
 rtl/serdes_pkg.sv | 23 ++
 rtl/comma_detect.sv | 25 ++
 rtl/comma_aligner.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared 8b/10b receive-side constants and the word-aligner state type.
package serdes_pkg;

    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2
    } align_state_e;

    // Candidate symbol at offset k is win[19-k -: 10].
    function automatic logic [9:0] extract_sym(input logic [19:0] win, input logic [3:0] off);
        logic [19:0] sh;
        sh = win >> (5'd10 - 5'(off));
        return sh[9:0];
    endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma search over a 20-bit window; reports the lowest matching offset.
module comma_detect
    import serdes_pkg::*;
(
    input  logic [19:0] win_i,
    output logic        hit_o,
    output logic [3:0]  pos_o
);

    logic [6:0] slice;

    always_comb begin
        hit_o = 1'b0;
        pos_o = '0;
        slice = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            slice = 7'(win_i >> (13 - i));
            if (!hit_o && (slice == COMMA_P || slice == COMMA_N)) begin
                hit_o = 1'b1;
                pos_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/comma_aligner.sv
// K28.5 word aligner with lock/unlock hysteresis feeding the 8b/10b decoder.
// Optional decoder-error lock monitor enabled by ALIGN_ERR_MON_EN.
module comma_aligner
    import serdes_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 4
`ifdef ALIGN_ERR_MON_EN
    ,
    parameter int unsigned ERR_WIN    = 16,
    parameter int unsigned ERR_MAX    = 4
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] rx_word,
    input  logic       rx_valid,
`ifdef ALIGN_ERR_MON_EN
    input  logic       code_err_in,
    input  logic       disp_err_in,
`endif
    output logic [9:0] datout,
    output logic       dvalid,
    output logic       comma_det,
    output logic       locked,
    output logic [3:0] offset
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    align_state_e state_q, state_d;
    logic [9:0]   prev_q, cur_q, datout_q, sym_d;
    logic [1:0]   fill_q;
    logic [3:0]   off_q, off_d, cnt_q, cnt_d, miss_q, miss_d, pos;
    logic         dvalid_q, cdet_q, hit, win_vld, adv, sym_comma;

    assign win_vld = (fill_q == 2'd2);
    // Each window is evaluated once, on the edge that accepts the following word.
    assign adv     = rx_valid && win_vld;

    comma_detect u_det (
        .win_i ({prev_q, cur_q}),
        .hit_o (hit),
        .pos_o (pos)
    );

`ifdef ALIGN_ERR_MON_EN
    localparam int unsigned EW = $clog2(ERR_WIN + ERR_MAX + 1);
    logic [EW-1:0] errs_q, errs_d, wcnt_q, wcnt_d, errs_inc, wcnt_inc;
    logic          err_unlock;

    always_comb begin
        errs_d     = errs_q;
        wcnt_d     = wcnt_q;
        err_unlock = 1'b0;
        errs_inc   = errs_q + EW'(code_err_in | disp_err_in);
        wcnt_inc   = wcnt_q + EW'(1);
        if (state_q != LOCKED) begin
            errs_d = '0;
            wcnt_d = '0;
        end else if (adv) begin
            if (errs_inc >= EW'(ERR_MAX)) begin
                err_unlock = 1'b1;
                errs_d     = '0;
                wcnt_d     = '0;
            end else if (wcnt_inc >= EW'(ERR_WIN)) begin
                errs_d = '0;
                wcnt_d = '0;
            end else begin
                errs_d = errs_inc;
                wcnt_d = wcnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            errs_q <= '0;
            wcnt_q <= '0;
        end else begin
            errs_q <= errs_d;
            wcnt_q <= wcnt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        if (adv && hit) begin
            case (state_q)
                UNLOCKED: begin
                    off_d = pos;
                    if (LOCK_N == 4'd1) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        state_d = CANDIDATE;
                        cnt_d   = 4'd1;
                    end
                end
                CANDIDATE: begin
                    if (pos != off_q) begin
                        off_d = pos;
                        cnt_d = 4'd1;
                    end else if (cnt_q + 4'd1 == LOCK_N) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                LOCKED: begin
                    if (pos == off_q) begin
                        miss_d = '0;
                    end else if (miss_q + 4'd1 == UNLOCK_N) begin
                        state_d = UNLOCKED;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
`ifdef ALIGN_ERR_MON_EN
        if (err_unlock) begin
            state_d = UNLOCKED;
            miss_d  = '0;
        end
`endif
    end

    // Extract at the next offset so datout always matches the offset registered with it.
    assign sym_d     = extract_sym({prev_q, cur_q}, off_d);
    assign sym_comma = (sym_d[9:3] == COMMA_P) || (sym_d[9:3] == COMMA_N);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            off_q    <= '0;
            cnt_q    <= '0;
            miss_q   <= '0;
            prev_q   <= '0;
            cur_q    <= '0;
            fill_q   <= '0;
            datout_q <= '0;
            dvalid_q <= 1'b0;
            cdet_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            dvalid_q <= adv;
            if (rx_valid) begin
                prev_q <= cur_q;
                cur_q  <= rx_word;
                if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            end
            if (adv) begin
                datout_q <= sym_d;
                cdet_q   <= sym_comma;
            end
        end
    end

    assign datout    = datout_q;
    assign dvalid    = dvalid_q;
    assign comma_det = cdet_q;
    assign locked    = (state_q == LOCKED);
    assign offset    = off_q;

endmodule
